rcl_query_sched: RTL and testbench

- Round-robin scheduler that shares one circle/line intersection engine among NUM_REQ requesters.
- The engine reports 0, 1 or 2 intersections between line a·x+b·y+c=0 and a circle of centre (m,n) and squared radius k.
- This block grants one query at a time and serialises its six coefficients into the engine's 3-beat stream.
- It waits for the engine result (with timeout), then returns the result with the requester ID over a valid/ready response channel.

---
 rtl/rcl_query_sched.sv | 182 ++++++++++++++++++
 tb/tb_rcl_query_sched.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcl_query_sched.sv
// Round-robin scheduler sharing one circle/line intersection engine among
// NUM_REQ requesters. A granted query's six coefficients are streamed to the
// engine as three (L,Q) beats; the engine result (or a timeout) is returned
// with the requester index over a valid/ready response channel.
module rcl_query_sched #(
    parameter int NUM_REQ    = 4,
    parameter int WAIT_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*30-1:0] req_coef,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rcl_in_valid,
    output logic [4:0]            rcl_coef_L,
    output logic [4:0]            rcl_coef_Q,
    input  logic                  rcl_out_valid,
    input  logic [1:0]            rcl_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_id,
    output logic [1:0]            rsp_result,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [15:0]           done_cnt
);

    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        WAIT  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [29:0]    coef_q, coef_d;
    logic [2:0]     id_q, id_d;
    logic [WCW-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]     result_q, result_d;
    logic           err_q, err_d;
    logic [15:0]    doneCnt_q, doneCnt_d;

    logic               grantHit;
    logic [2:0]         grantIdx;
    logic [NUM_REQ-1:0] grantVec;
    logic [29:0]        grantCoef;

    // Round-robin pick: first pending requester at or above the pointer, else wrap to the lowest one
    always_comb begin
        grantHit  = 1'b0;
        grantIdx  = '0;
        grantVec  = '0;
        grantCoef = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grantHit && req_valid[i] && (i >= int'(ptr_q))) begin
                grantHit    = 1'b1;
                grantIdx    = 3'(i);
                grantVec[i] = 1'b1;
                grantCoef   = req_coef[i*30 +: 30];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grantHit && req_valid[i] && (i < int'(ptr_q))) begin
                grantHit    = 1'b1;
                grantIdx    = 3'(i);
                grantVec[i] = 1'b1;
                grantCoef   = req_coef[i*30 +: 30];
            end
        end
    end

    // State and datapath registers; reset drops any in-flight query
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            coef_q    <= '0;
            id_q      <= '0;
            waitCnt_q <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            doneCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            coef_q    <= coef_d;
            id_q      <= id_d;
            waitCnt_q <= waitCnt_d;
            result_q  <= result_d;
            err_q     <= err_d;
            doneCnt_q <= doneCnt_d;
        end
    end

    // Next-state: grant, stream three beats, wait for the engine with a timeout, then hold the response
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        coef_d    = coef_q;
        id_d      = id_q;
        waitCnt_d = waitCnt_q;
        result_d  = result_q;
        err_d     = err_q;
        doneCnt_d = doneCnt_q;
        unique case (state_q)
            IDLE: begin
                if (grantHit) begin
                    state_d = SEND0;
                    coef_d  = grantCoef;
                    id_d    = grantIdx;
                    ptr_d   = (grantIdx == 3'(NUM_REQ - 1)) ? 3'd0 : grantIdx + 3'd1;
                end
            end
            SEND0: state_d = SEND1;
            SEND1: state_d = SEND2;
            SEND2: begin
                state_d   = WAIT;
                waitCnt_d = '0;
            end
            WAIT: begin
                if (rcl_out_valid) begin
                    result_d = rcl_out;
                    err_d    = (rcl_out == 2'd3);
                    state_d  = RESP;
                end else if (waitCnt_q == WCW'(WAIT_LIMIT - 1)) begin
                    result_d = 2'd0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    waitCnt_d = waitCnt_q + WCW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d   = IDLE;
                    doneCnt_d = doneCnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant only in IDLE and out of reset; engine bus driven only during the three send beats
    always_comb begin
        req_ready    = '0;
        rcl_in_valid = 1'b0;
        rcl_coef_L   = '0;
        rcl_coef_Q   = '0;
        case (state_q)
            IDLE: req_ready = rst_n ? grantVec : '0;
            SEND0: begin
                rcl_in_valid = 1'b1;
                rcl_coef_L   = coef_q[29:25];
                rcl_coef_Q   = coef_q[14:10];
            end
            SEND1: begin
                rcl_in_valid = 1'b1;
                rcl_coef_L   = coef_q[24:20];
                rcl_coef_Q   = coef_q[9:5];
            end
            SEND2: begin
                rcl_in_valid = 1'b1;
                rcl_coef_L   = coef_q[19:15];
                rcl_coef_Q   = coef_q[4:0];
            end
            default: ;
        endcase
    end

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign done_cnt   = doneCnt_q;

endmodule

// File: tb/tb_rcl_query_sched.sv
// Directed bench for rcl_query_sched with a behavioural intersection engine.
module tb_rcl_query_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [29:0]  coef0, coef1, coef2, coef3;
    logic [119:0] req_coef;
    logic [3:0]   req_ready;
    logic         rcl_in_valid;
    logic [4:0]   rcl_coef_L, rcl_coef_Q;
    logic         rcl_out_valid;
    logic [1:0]   rcl_out;
    logic         rsp_valid, rsp_ready;
    logic [2:0]   rsp_id;
    logic [1:0]   rsp_result;
    logic         rsp_err, busy;
    logic [15:0]  done_cnt;

    int checks = 0;
    int errors = 0;

    // engine model state; engMode 0 = normal, 1 = never answers, 2 = answers 3
    int         engMode;
    logic       forceOv;
    logic [1:0] engBeat;
    logic       engStage, engOv;
    logic [1:0] engOut;
    logic [4:0] la, lb, lc, qm, qn, qk;

    assign req_coef      = {coef3, coef2, coef1, coef0};
    assign rcl_out_valid = engOv | forceOv;
    assign rcl_out       = engOut;

    always #5 clk = ~clk;

    rcl_query_sched #(.NUM_REQ(4), .WAIT_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_coef(req_coef), .req_ready(req_ready),
        .rcl_in_valid(rcl_in_valid), .rcl_coef_L(rcl_coef_L), .rcl_coef_Q(rcl_coef_Q),
        .rcl_out_valid(rcl_out_valid), .rcl_out(rcl_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy), .done_cnt(done_cnt)
    );

    function automatic logic [29:0] pack(input int a, input int b, input int c,
                                         input int m, input int n, input int k);
        return {5'(a), 5'(b), 5'(c), 5'(m), 5'(n), 5'(k)};
    endfunction

    // intersection count from squared distance of centre to line against k*(a^2+b^2)
    function automatic logic [1:0] engCount(input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] c, input logic [4:0] m,
                                            input logic [4:0] n, input logic [4:0] k);
        int ai, bi, ci, mi, ni, ki, d, lhs, rhs;
        ai = int'($signed(a)); bi = int'($signed(b)); ci = int'($signed(c));
        mi = int'($signed(m)); ni = int'($signed(n)); ki = int'(k);
        d   = ai * mi + bi * ni + ci;
        lhs = d * d;
        rhs = ki * (ai * ai + bi * bi);
        if (lhs < rhs) return 2'd2;
        else if (lhs == rhs) return 2'd1;
        else return 2'd0;
    endfunction

    // engine: collects three beats, answers two cycles after the last beat
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            engBeat <= 2'd0; engStage <= 1'b0; engOv <= 1'b0; engOut <= 2'd0;
            la <= '0; lb <= '0; lc <= '0; qm <= '0; qn <= '0; qk <= '0;
        end else begin
            engOv <= 1'b0;
            if (engStage) begin
                engStage <= 1'b0;
                if (engMode == 2) begin
                    engOv <= 1'b1; engOut <= 2'd3;
                end else if (engMode == 0) begin
                    engOv <= 1'b1; engOut <= engCount(la, lb, lc, qm, qn, qk);
                end
            end
            if (rcl_in_valid) begin
                case (engBeat)
                    2'd0: begin la <= rcl_coef_L; qm <= rcl_coef_Q; engBeat <= 2'd1; end
                    2'd1: begin lb <= rcl_coef_L; qn <= rcl_coef_Q; engBeat <= 2'd2; end
                    default: begin
                        lc <= rcl_coef_L; qk <= rcl_coef_Q; engBeat <= 2'd0; engStage <= 1'b1;
                    end
                endcase
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // issue one query (requester must win immediately) and wait for its response
    task automatic doQuery(input logic [3:0] mask, output int lat, output logic [2:0] id,
                           output logic [1:0] res, output logic err);
        lat = -1; id = '0; res = '0; err = 1'b0;
        req_valid = mask;
        for (int c = 1; c <= 30; c++) begin
            tick;
            req_valid = 4'b0000;
            if (rsp_valid) begin
                lat = c; id = rsp_id; res = rsp_result; err = rsp_err;
                break;
            end
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 4'b0010; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if ({rcl_in_valid, rcl_coef_L, rcl_coef_Q, rsp_valid, rsp_id, rsp_result, rsp_err, busy, done_cnt} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {rcl_in_valid, rcl_coef_L, rcl_coef_Q, rsp_valid, rsp_id, rsp_result, rsp_err, busy, done_cnt});
        end
        req_valid = 4'b0000;
        tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_round_robin;
        int gr, rs;
        logic [3:0] expMask;
        logic [9:0] resVec;
        logic [1:0] expRes;
        gr = 0; rs = 0;
        resVec = {2'd2, 2'd2, 2'd0, 2'd1, 2'd2};
        coef0 = pack(1, 0, 0, 0, 0, 1);
        coef1 = pack(1, 0, -1, 0, 0, 1);
        coef2 = pack(1, 0, -2, 0, 0, 1);
        coef3 = pack(0, 1, 0, 0, 0, 4);
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 100 && rs < 5; c++) begin
            if (req_ready !== 4'b0000) begin
                expMask = 4'b0001 << (gr % 4);
                checks++;
                if (req_ready !== expMask) begin
                    errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", gr, req_ready, expMask);
                end
                gr++;
            end
            if (rsp_valid) begin
                expRes = 2'(resVec >> (2 * rs));
                checks++;
                if ({rsp_id, rsp_result, rsp_err} !== {3'(rs % 4), expRes, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL rr_rsp%0d: got id=%0d res=%0d err=%b expected id=%0d res=%0d err=0",
                             rs, rsp_id, rsp_result, rsp_err, rs % 4, expRes);
                end
                rs++;
                if (rs == 5) req_valid = 4'b0000;
            end
            tick;
        end
        checks++;
        if (gr != 5 || rs != 5) begin
            errors++; $display("[TB] FAIL rr_count: got grants=%0d rsps=%0d expected 5 and 5", gr, rs);
        end
        checks++;
        if (done_cnt !== 16'd5) begin
            errors++; $display("[TB] FAIL rr_done_cnt: got %0d expected 5", done_cnt);
        end
    endtask

    task automatic test_tangent;
        coef2 = pack(1, 0, -1, 0, 0, 1);
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("[TB] FAIL tan_grant: got %b expected 0100", req_ready);
        end
        tick;
        req_valid = 4'b0000;
        checks++;
        if ({rcl_in_valid, rcl_coef_L, rcl_coef_Q} !== {1'b1, 5'd1, 5'd0}) begin
            errors++; $display("[TB] FAIL tan_beat0: got %b/%h/%h expected 1/01/00", rcl_in_valid, rcl_coef_L, rcl_coef_Q);
        end
        tick;
        checks++;
        if ({rcl_in_valid, rcl_coef_L, rcl_coef_Q} !== {1'b1, 5'd0, 5'd0}) begin
            errors++; $display("[TB] FAIL tan_beat1: got %b/%h/%h expected 1/00/00", rcl_in_valid, rcl_coef_L, rcl_coef_Q);
        end
        tick;
        checks++;
        if ({rcl_in_valid, rcl_coef_L, rcl_coef_Q} !== {1'b1, 5'h1F, 5'd1}) begin
            errors++; $display("[TB] FAIL tan_beat2: got %b/%h/%h expected 1/1f/01", rcl_in_valid, rcl_coef_L, rcl_coef_Q);
        end
        tick;
        checks++;
        if ({rcl_in_valid, rcl_coef_L, rcl_coef_Q, rsp_valid} !== 12'd0) begin
            errors++; $display("[TB] FAIL tan_wait_bus: got %b/%h/%h rsp_valid=%b expected all 0",
                               rcl_in_valid, rcl_coef_L, rcl_coef_Q, rsp_valid);
        end
        tick;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL tan_early_rsp: got %b expected 0", rsp_valid);
        end
        tick;
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== {1'b1, 3'd2, 2'd1, 1'b0}) begin
            errors++; $display("[TB] FAIL tan_rsp: got v=%b id=%0d res=%0d err=%b expected v=1 id=2 res=1 err=0",
                               rsp_valid, rsp_id, rsp_result, rsp_err);
        end
        tick;
        checks++;
        if ({busy, done_cnt} !== {1'b0, 16'd6}) begin
            errors++; $display("[TB] FAIL tan_done: got busy=%b done=%0d expected busy=0 done=6", busy, done_cnt);
        end
    endtask

    task automatic test_secant_miss;
        int lat; logic [2:0] id; logic [1:0] res; logic err;
        coef2 = pack(1, 0, 0, 0, 0, 1);
        doQuery(4'b0100, lat, id, res, err);
        checks++;
        if (lat != 6 || {id, res, err} !== {3'd2, 2'd2, 1'b0}) begin
            errors++; $display("[TB] FAIL secant: got lat=%0d id=%0d res=%0d err=%b expected lat=6 id=2 res=2 err=0",
                               lat, id, res, err);
        end
        coef2 = pack(1, 0, -2, 0, 0, 1);
        doQuery(4'b0100, lat, id, res, err);
        checks++;
        if (lat != 6 || {id, res, err} !== {3'd2, 2'd0, 1'b0}) begin
            errors++; $display("[TB] FAIL miss: got lat=%0d id=%0d res=%0d err=%b expected lat=6 id=2 res=0 err=0",
                               lat, id, res, err);
        end
        checks++;
        if (done_cnt !== 16'd8) begin
            errors++; $display("[TB] FAIL sm_done_cnt: got %0d expected 8", done_cnt);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        coef2 = pack(1, 0, -1, 0, 0, 1);
        coef1 = pack(1, 0, -1, 0, 0, 1);
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            req_valid = 4'b0010;
            if (rsp_valid) begin lat = c; break; end
        end
        checks++;
        if (lat != 6) begin
            errors++; $display("[TB] FAIL bp_latency: got %0d expected 6", lat);
        end
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) rsp_ready = 1'b1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_err, req_ready} !== {1'b1, 3'd2, 2'd1, 1'b0, 4'b0000}) begin
                errors++; $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d res=%0d err=%b rdy=%b expected 1/2/1/0/0000",
                                   k, rsp_valid, rsp_id, rsp_result, rsp_err, req_ready);
            end
            tick;
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL bp_next_grant: got %b expected 0010", req_ready);
        end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            req_valid = 4'b0000;
            if (rsp_valid) begin lat = c; break; end
        end
        checks++;
        if (lat != 6 || {rsp_id, rsp_result, rsp_err} !== {3'd1, 2'd1, 1'b0}) begin
            errors++; $display("[TB] FAIL bp_follow: got lat=%0d id=%0d res=%0d err=%b expected lat=6 id=1 res=1 err=0",
                               lat, rsp_id, rsp_result, rsp_err);
        end
        tick;
        checks++;
        if (done_cnt !== 16'd10) begin
            errors++; $display("[TB] FAIL bp_done_cnt: got %0d expected 10", done_cnt);
        end
    endtask

    task automatic test_timeout_illegal;
        int lat; logic [2:0] id; logic [1:0] res; logic err;
        forceOv = 1'b1;
        tick;
        forceOv = 1'b0;
        checks++;
        if ({busy, rsp_valid, done_cnt} !== {1'b0, 1'b0, 16'd10}) begin
            errors++; $display("[TB] FAIL stray_out_valid: got busy=%b v=%b done=%0d expected 0/0/10",
                               busy, rsp_valid, done_cnt);
        end
        coef2 = pack(1, 0, -1, 0, 0, 1);
        engMode = 1;
        doQuery(4'b0100, lat, id, res, err);
        checks++;
        if (lat != 12 || {id, res, err} !== {3'd2, 2'd0, 1'b1}) begin
            errors++; $display("[TB] FAIL timeout: got lat=%0d id=%0d res=%0d err=%b expected lat=12 id=2 res=0 err=1",
                               lat, id, res, err);
        end
        engMode = 2;
        doQuery(4'b0100, lat, id, res, err);
        checks++;
        if (lat != 6 || {id, res, err} !== {3'd2, 2'd3, 1'b1}) begin
            errors++; $display("[TB] FAIL illegal: got lat=%0d id=%0d res=%0d err=%b expected lat=6 id=2 res=3 err=1",
                               lat, id, res, err);
        end
        engMode = 0;
        checks++;
        if (done_cnt !== 16'd12) begin
            errors++; $display("[TB] FAIL ti_done_cnt: got %0d expected 12", done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [2:0] id; logic [1:0] res; logic err;
        coef0 = pack(1, 0, 0, 0, 0, 1);
        coef1 = pack(1, 0, -1, 0, 0, 1);
        req_valid = 4'b0010;
        tick;
        req_valid = 4'b0000;
        tick;
        checks++;
        if (rcl_in_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL rm_in_send1: got %b expected 1", rcl_in_valid);
        end
        rst_n = 1'b0;
        req_valid = 4'b1001;
        #1;
        checks++;
        if ({req_ready, rcl_in_valid, rcl_coef_L, rcl_coef_Q, rsp_valid, rsp_id, rsp_result, rsp_err, busy, done_cnt} !== 40'd0) begin
            errors++;
            $display("[TB] FAIL rm_outputs: got %h expected 0",
                     {req_ready, rcl_in_valid, rcl_coef_L, rcl_coef_Q, rsp_valid, rsp_id, rsp_result, rsp_err, busy, done_cnt});
        end
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL rm_ptr: got %b expected 0001", req_ready);
        end
        doQuery(4'b1001, lat, id, res, err);
        checks++;
        if (lat != 6 || {id, res, err} !== {3'd0, 2'd2, 1'b0}) begin
            errors++; $display("[TB] FAIL rm_query: got lat=%0d id=%0d res=%0d err=%b expected lat=6 id=0 res=2 err=0",
                               lat, id, res, err);
        end
        checks++;
        if (done_cnt !== 16'd1) begin
            errors++; $display("[TB] FAIL rm_done_cnt: got %0d expected 1", done_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b1;
        forceOv = 1'b0; engMode = 0;
        coef0 = '0; coef1 = '0; coef2 = '0; coef3 = '0;
        test_reset;
        test_round_robin;
        test_tangent;
        test_secant_miss;
        test_backpressure;
        test_timeout_illegal;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1);
    end

endmodule
